amba3_axi_rom_slave: RTL

// - Synthesizable AMBA3 AXI read-only slave. Sits directly downstream of the AXI master in the amba3 testbench.
// - Consumes the AR channel and returns address-derived data on the R channel.
// - Benches check master read bursts against a known, computable data pattern without a behavioural memory model.

---
 rtl/amba3_axi_rom_slave_if.sv | 39 +++
 rtl/amba3_axi_rom_slave.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/amba3_axi_rom_slave_if.sv
// ---------------------------------------------------------------------------
// amba3_axi_rom_slave_if
// AMBA3 AXI read-only bundle (AR and R channels) between a read master and
// the ROM slave.
//   AR channel : arid, araddr, arlen, arsize, arburst, arvalid (master -> slave)
//                arready (slave -> master)
//   R channel  : rid, rdata, rresp, rlast, rvalid (slave -> master)
//                rready (master -> slave)
// Modports: master (drives AR, accepts R), slave (accepts AR, drives R).
// ---------------------------------------------------------------------------
interface amba3_axi_rom_slave_if #(
    parameter int AXID_SIZE = 4,
    parameter int ADDR_SIZE = 32,
    parameter int DATA_SIZE = 128
);
    logic [AXID_SIZE-1:0] arid;
    logic [ADDR_SIZE-1:0] araddr;
    logic [3:0]           arlen;
    logic [2:0]           arsize;
    logic [1:0]           arburst;
    logic                 arvalid;
    logic                 arready;
    logic [AXID_SIZE-1:0] rid;
    logic [DATA_SIZE-1:0] rdata;
    logic [1:0]           rresp;
    logic                 rlast;
    logic                 rvalid;
    logic                 rready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arvalid, rready,
        input  arready, rid, rdata, rresp, rlast, rvalid
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
        output arready, rid, rdata, rresp, rlast, rvalid
    );
endinterface

// File: rtl/amba3_axi_rom_slave.sv
// ---------------------------------------------------------------------------
// amba3_axi_rom_slave
// AMBA3 AXI read-only slave returning address-derived data. Each 32-bit lane k
// of a beat carries (bus-aligned beat address + 4*k), so a bench can check a
// read burst without any memory model.
// Ports:
//   aclk   : clock, rising edge
//   areset : asynchronous reset, active-high
//   bus    : amba3_axi_rom_slave_if.slave (AR in, R out)
// Optional feature: define AMBA3_AXI_ROM_ERR_EN to return DECERR for start
// addresses outside [BASE_ADDR, BASE_ADDR+MEM_BYTES) and SLVERR for reserved
// bursts, oversize beats or illegal WRAP lengths (rdata forced to zero).
// Without the macro every burst is OKAY and reserved bursts behave as INCR.
// ---------------------------------------------------------------------------
module amba3_axi_rom_slave #(
    parameter int                   AXID_SIZE = 4,
    parameter int                   ADDR_SIZE = 32,
    parameter int                   DATA_SIZE = 128,
    parameter logic [ADDR_SIZE-1:0] BASE_ADDR = {ADDR_SIZE{1'b0}},
    parameter logic [ADDR_SIZE-1:0] MEM_BYTES = ADDR_SIZE'(32'h0000_1000)
) (
    input  logic                  aclk,
    input  logic                  areset,
    amba3_axi_rom_slave_if.slave  bus
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] BURST_RSVD  = 2'b11;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam int                   LANES     = DATA_SIZE / 32;
    localparam logic [ADDR_SIZE-1:0] ADDR_ONE  = ADDR_SIZE'(1'b1);
    localparam logic [ADDR_SIZE-1:0] BUS_BYTES = ADDR_SIZE'(DATA_SIZE / 8);

`ifdef AMBA3_AXI_ROM_ERR_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    // Data pattern: lane k = bus-aligned address + 4*k, truncated to 32 bits.
    function automatic logic [DATA_SIZE-1:0] lane_pattern(input logic [ADDR_SIZE-1:0] addr);
        logic [ADDR_SIZE-1:0] base;
        logic [DATA_SIZE-1:0] word;
        base = addr & ~(BUS_BYTES - ADDR_ONE);
        word = {DATA_SIZE{1'b0}};
        for (int k = 0; k < LANES; k++) begin
            word[32*k +: 32] = 32'(base + ADDR_SIZE'(4 * k));
        end
        return word;
    endfunction

    state_t               state_r;
    logic                 arready_r;
    logic                 rvalid_r;
    logic                 rlast_r;
    logic [AXID_SIZE-1:0] rid_r;
    logic [DATA_SIZE-1:0] rdata_r;
    logic [1:0]           rresp_r;
    logic [ADDR_SIZE-1:0] addr_r;
    logic [3:0]           len_r;
    logic [2:0]           size_r;
    logic [1:0]           burst_r;
    logic [3:0]           beat_cnt_r;
    logic [ADDR_SIZE-1:0] wrap_lo_r;
    logic [ADDR_SIZE-1:0] wrap_hi_r;

    logic [ADDR_SIZE-1:0] ar_beat_bytes_s;
    logic [ADDR_SIZE-1:0] ar_wrap_bytes_s;
    logic [ADDR_SIZE-1:0] ar_wrap_lo_s;
    logic [ADDR_SIZE:0]   win_end_s;
    logic                 dec_miss_s;
    logic                 slv_bad_s;
    logic [1:0]           ar_resp_s;
    logic [ADDR_SIZE-1:0] beat_bytes_s;
    logic [ADDR_SIZE-1:0] incr_addr_s;
    logic [ADDR_SIZE-1:0] next_addr_s;

    assign bus.arready = arready_r;
    assign bus.rvalid  = rvalid_r;
    assign bus.rlast   = rlast_r;
    assign bus.rid     = rid_r;
    assign bus.rdata   = rdata_r;
    assign bus.rresp   = rresp_r;

    // AR-side decode: wrap window of the incoming burst and its error class.
    always_comb begin
        ar_beat_bytes_s = ADDR_ONE << bus.arsize;
        ar_wrap_bytes_s = ar_beat_bytes_s * (ADDR_SIZE'(bus.arlen) + ADDR_ONE);
        // Only meaningful when the wrap size is a power of two (legal WRAP lengths).
        ar_wrap_lo_s    = bus.araddr & ~(ar_wrap_bytes_s - ADDR_ONE);
        // One extra bit so BASE_ADDR+MEM_BYTES cannot overflow the compare.
        win_end_s       = {1'b0, BASE_ADDR} + {1'b0, MEM_BYTES};
        dec_miss_s      = (bus.araddr < BASE_ADDR) || ({1'b0, bus.araddr} >= win_end_s);
        slv_bad_s       = (bus.arburst == BURST_RSVD) ||
                          (ar_beat_bytes_s > BUS_BYTES) ||
                          ((bus.arburst == BURST_WRAP) &&
                           !(bus.arlen inside {4'd1, 4'd3, 4'd7, 4'd15}));
        ar_resp_s       = RESP_OKAY;
        if (ERR_EN && dec_miss_s) begin
            ar_resp_s = RESP_DECERR;
        end else if (ERR_EN && slv_bad_s) begin
            ar_resp_s = RESP_SLVERR;
        end else begin
            ar_resp_s = RESP_OKAY;
        end
    end

    // Next beat address from the current one; reserved bursts follow INCR.
    always_comb begin
        beat_bytes_s = ADDR_ONE << size_r;
        incr_addr_s  = (addr_r & ~(beat_bytes_s - ADDR_ONE)) + beat_bytes_s;
        next_addr_s  = incr_addr_s;
        case (burst_r)
            BURST_FIXED: next_addr_s = addr_r;
            BURST_WRAP:  next_addr_s = (incr_addr_s == wrap_hi_r) ? wrap_lo_r : incr_addr_s;
            BURST_INCR,
            BURST_RSVD:  next_addr_s = incr_addr_s;
            default:     next_addr_s = incr_addr_s;
        endcase
    end

    // Read FSM: accept one AR in IDLE, stream len+1 registered beats in BURST.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_r    <= ST_IDLE;
            arready_r  <= 1'b0;
            rvalid_r   <= 1'b0;
            rlast_r    <= 1'b0;
            rid_r      <= {AXID_SIZE{1'b0}};
            rdata_r    <= {DATA_SIZE{1'b0}};
            rresp_r    <= RESP_OKAY;
            addr_r     <= {ADDR_SIZE{1'b0}};
            len_r      <= 4'd0;
            size_r     <= 3'd0;
            burst_r    <= BURST_FIXED;
            beat_cnt_r <= 4'd0;
            wrap_lo_r  <= {ADDR_SIZE{1'b0}};
            wrap_hi_r  <= {ADDR_SIZE{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.arvalid && arready_r) begin
                        arready_r  <= 1'b0;
                        rvalid_r   <= 1'b1;
                        rlast_r    <= (bus.arlen == 4'd0);
                        rid_r      <= bus.arid;
                        rresp_r    <= ar_resp_s;
                        rdata_r    <= (ar_resp_s == RESP_OKAY) ? lane_pattern(bus.araddr)
                                                               : {DATA_SIZE{1'b0}};
                        addr_r     <= bus.araddr;
                        len_r      <= bus.arlen;
                        size_r     <= bus.arsize;
                        burst_r    <= bus.arburst;
                        beat_cnt_r <= 4'd0;
                        wrap_lo_r  <= ar_wrap_lo_s;
                        wrap_hi_r  <= ar_wrap_lo_s + ar_wrap_bytes_s;
                        state_r    <= ST_BURST;
                    end else begin
                        // Also raises arready on the first edge after reset release.
                        arready_r <= 1'b1;
                    end
                end
                ST_BURST: begin
                    if (rvalid_r && bus.rready) begin
                        if (beat_cnt_r == len_r) begin
                            rvalid_r  <= 1'b0;
                            rlast_r   <= 1'b0;
                            arready_r <= 1'b1;
                            state_r   <= ST_IDLE;
                        end else begin
                            beat_cnt_r <= beat_cnt_r + 4'd1;
                            addr_r     <= next_addr_s;
                            rlast_r    <= ((beat_cnt_r + 4'd1) == len_r);
                            rdata_r    <= (rresp_r == RESP_OKAY) ? lane_pattern(next_addr_s)
                                                                 : {DATA_SIZE{1'b0}};
                        end
                    end else begin
                        // Stalled: all R outputs hold their registered values.
                        state_r <= ST_BURST;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
